// File: rtl/endat_pkg.sv
// Shared definitions for the EnDat position-processing slice.
//   state_t     : position FSM states (IDLE, RUN, FAULT)
//   JUMP_LIMIT  : consecutive rejected samples that force FAULT
//   wrap_delta  : modular single-turn difference, sign-extended to 32 bits
package endat_pkg;

   typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

   localparam int JUMP_LIMIT = 3;

   // (st - last_st) mod 2^n, read back as a signed n-bit value.
   // This lets a turn boundary crossed in either direction look like a small step.
   // n is passed in because the single-turn width is a module parameter (n <= 32).
   function automatic logic signed [31:0] wrap_delta(input logic [31:0] st,
                                                     input logic [31:0] last_st,
                                                     input int n);
      logic [31:0] mask;
      logic [31:0] d;
      mask = (n >= 32) ? '1 : ((32'd1 << n) - 32'd1);
      d    = (st - last_st) & mask;
      if ((d & (32'd1 << (n - 1))) != 32'd0)
         d = d | ~mask;
      return signed'(d);
   endfunction

endpackage

// File: rtl/endat_vel_win.sv
// Windowed velocity: sums 2^AVG_LOG accepted deltas, then publishes the sum.
//   enc_clk, rst : clock, synchronous active-high reset
//   delta        : signed single-turn delta of the current sample
//   acc          : accept strobe, add delta into the window
//   clr          : restart the window and zero the published velocity
//   vel          : signed sum of the last complete window
//   vel_vld      : one-cycle pulse when vel is updated
module endat_vel_win
   import endat_pkg::*;
#(
   parameter int ST_BITS = 23,
   parameter int AVG_LOG = 4
) (
   input  logic                     enc_clk,
   input  logic                     rst,
   input  logic [ST_BITS-1:0]       delta,
   input  logic                     acc,
   input  logic                     clr,
   output logic [ST_BITS+AVG_LOG:0] vel,
   output logic                     vel_vld
);

   localparam int VW = ST_BITS + AVG_LOG + 1;

   logic [VW-1:0]      vel_acc;
   logic [AVG_LOG-1:0] smp_cnt;
   logic [VW-1:0]      delta_x;

   assign delta_x = {{(VW-ST_BITS){delta[ST_BITS-1]}}, delta};

   always_ff @(posedge enc_clk) begin
      if (rst) begin
         vel_acc <= '0;
         smp_cnt <= '0;
         vel     <= '0;
         vel_vld <= 1'b0;
      end else begin
         vel_vld <= 1'b0;
         if (clr) begin
            vel_acc <= '0;
            smp_cnt <= '0;
            vel     <= '0;
         end else if (acc) begin
            // last delta of the window goes straight into vel
            if (smp_cnt == '1) begin
               vel     <= vel_acc + delta_x;
               vel_vld <= 1'b1;
               vel_acc <= '0;
               smp_cnt <= '0;
            end else begin
               vel_acc <= vel_acc + delta_x;
               smp_cnt <= smp_cnt + AVG_LOG'(1);
            end
         end
      end
   end

endmodule

// File: rtl/endat_pos_proc.sv
// EnDat position post-processing: single-turn unwrap into an extended signed
// position, jump rejection, windowed velocity and receiver-stall timeout.
//   enc_clk, rst : clock, synchronous active-high reset
//   pos_in       : captured position word (only ST_BITS low bits used)
//   pos_vld      : one-cycle strobe for pos_in
//   fault_clr    : leave FAULT, return to IDLE
//   pos_ext      : signed extended position (wraps at ACC_W)
//   pos_ext_vld  : level, pos_ext is trustworthy
//   vel, vel_vld : windowed delta sum and its update pulse
//   jump_err     : one-cycle pulse per rejected sample
//   timeout_err  : level, set by sample timeout, cleared by fault_clr
//   fault        : level, FSM is in FAULT
module endat_pos_proc
   import endat_pkg::*;
#(
   parameter int POS_W    = 40,
   parameter int ST_BITS  = 23,
   parameter int ACC_W    = 48,
   parameter int MAX_STEP = 65536,
   parameter int AVG_LOG  = 4,
   parameter int TIMEOUT  = 4096
) (
   input  logic                     enc_clk,
   input  logic                     rst,
   input  logic [POS_W-1:0]         pos_in,
   input  logic                     pos_vld,
   input  logic                     fault_clr,
   output logic [ACC_W-1:0]         pos_ext,
   output logic                     pos_ext_vld,
   output logic [ST_BITS+AVG_LOG:0] vel,
   output logic                     vel_vld,
   output logic                     jump_err,
   output logic                     timeout_err,
   output logic                     fault
);

   localparam int TMO_W = $clog2(TIMEOUT);

   state_t             state, state_nx;
   logic [ST_BITS-1:0] st, last_st, delta, mag;
   logic [1:0]         jump_cnt;
   logic [TMO_W-1:0]   tmo_cnt;
   logic               step_ok, rebase, do_acc, do_rej, tmo_hit, win_clr;
   logic               unused_hi;

   // multi-turn and upper bits of the word are deliberately ignored
   assign unused_hi = ^pos_in[POS_W-1:ST_BITS];

   assign st    = pos_in[ST_BITS-1:0];
   assign delta = ST_BITS'(wrap_delta(32'(st), 32'(last_st), ST_BITS));
   assign mag   = delta[ST_BITS-1] ? (~delta + ST_BITS'(1)) : delta;
   // the most negative delta has magnitude 2^(ST_BITS-1) > MAX_STEP, so it
   // always falls on the reject side of this compare
   assign step_ok = (mag <= ST_BITS'(MAX_STEP));

   always_ff @(posedge enc_clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      rebase   = 1'b0;
      do_acc   = 1'b0;
      do_rej   = 1'b0;
      tmo_hit  = 1'b0;
      case (state)
         IDLE: if (pos_vld) begin
            rebase   = 1'b1;
            state_nx = RUN;
         end
         RUN: begin
            if (pos_vld) begin
               if (step_ok) begin
                  do_acc = 1'b1;
               end else begin
                  do_rej = 1'b1;
                  if (jump_cnt == 2'(JUMP_LIMIT-1)) state_nx = FAULT;
               end
            end else if (tmo_cnt == TMO_W'(TIMEOUT-1)) begin
               tmo_hit  = 1'b1;
               state_nx = FAULT;
            end
         end
         FAULT: if (fault_clr) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      // velocity window restarts on rebase; vel reads 0 throughout FAULT
      win_clr = rebase || (state != FAULT && state_nx == FAULT);
   end

   always_ff @(posedge enc_clk) begin
      if (rst) begin
         last_st     <= '0;
         pos_ext     <= '0;
         pos_ext_vld <= 1'b0;
         jump_cnt    <= '0;
         tmo_cnt     <= '0;
         jump_err    <= 1'b0;
         timeout_err <= 1'b0;
         fault       <= 1'b0;
      end else begin
         jump_err <= do_rej;
         if (rebase) begin
            last_st     <= st;
            pos_ext     <= ACC_W'(st);
            pos_ext_vld <= 1'b1;
            jump_cnt    <= '0;
         end
         if (do_acc) begin
            last_st  <= st;
            pos_ext  <= pos_ext + {{(ACC_W-ST_BITS){delta[ST_BITS-1]}}, delta};
            jump_cnt <= '0;
         end
         if (do_rej) jump_cnt <= jump_cnt + 2'd1;
         tmo_cnt <= (state == RUN && !pos_vld && !tmo_hit) ? tmo_cnt + TMO_W'(1) : '0;
         if (tmo_hit) timeout_err <= 1'b1;
         if (state != FAULT && state_nx == FAULT) begin
            fault       <= 1'b1;
            pos_ext_vld <= 1'b0;
         end
         if (state == FAULT && state_nx == IDLE) begin
            fault       <= 1'b0;
            timeout_err <= 1'b0;
         end
      end
   end

   endat_vel_win #(
      .ST_BITS (ST_BITS),
      .AVG_LOG (AVG_LOG)
   ) u_vel_win (
      .enc_clk (enc_clk),
      .rst     (rst),
      .delta   (delta),
      .acc     (do_acc),
      .clr     (win_clr),
      .vel     (vel),
      .vel_vld (vel_vld)
   );

endmodule

// File: tb/tb_endat_pos_proc.sv
// Scoreboard bench for endat_pos_proc (ST_BITS=8, MAX_STEP=16, AVG_LOG=2,
// TIMEOUT=20, ACC_W=16). Stimulus pushes expected output snapshots tagged with
// the cycle they are due; the monitor pops and compares on the falling edge.
// Expected velocity values go to a separate queue popped on every vel_vld.
module tb_endat_pos_proc;

   logic        enc_clk = 1'b0;
   logic        rst, pos_vld, fault_clr;
   logic [39:0] pos_in;
   logic [15:0] pos_ext;
   logic [10:0] vel;
   logic        pos_ext_vld, vel_vld, jump_err, timeout_err, fault;

   int cyc = 0;
   int checks = 0;
   int errs = 0;

   typedef struct {
      int          due;
      string       name;
      logic [15:0] pe;
      logic        pev, je, vv;
      logic [10:0] vl;
      logic        te, f;
   } exp_t;

   exp_t        sb[$];
   logic [10:0] vq[$];

   endat_pos_proc #(
      .POS_W(40), .ST_BITS(8), .ACC_W(16), .MAX_STEP(16), .AVG_LOG(2), .TIMEOUT(20)
   ) dut (
      .enc_clk(enc_clk), .rst(rst), .pos_in(pos_in), .pos_vld(pos_vld),
      .fault_clr(fault_clr), .pos_ext(pos_ext), .pos_ext_vld(pos_ext_vld),
      .vel(vel), .vel_vld(vel_vld), .jump_err(jump_err),
      .timeout_err(timeout_err), .fault(fault)
   );

   always #5 enc_clk = ~enc_clk;
   always @(posedge enc_clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errs++;
         $display("FAIL %s got=0x%0h exp=0x%0h", nm, act, expv);
      end
   endtask

   // monitor
   always @(negedge enc_clk) begin
      if (vel_vld) begin
         if (vq.size() == 0) begin
            checks++;
            errs++;
            $display("FAIL unexpected_vel_vld got=0x%0h exp=none", vel);
         end else begin
            logic [10:0] v;
            v = vq.pop_front();
            chk("vel_value", 32'(vel), 32'(v));
         end
      end
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         exp_t e;
         e = sb.pop_front();
         chk({e.name, ".due"}, e.due, cyc);
         chk({e.name, ".pos_ext"}, 32'(pos_ext), 32'(e.pe));
         chk({e.name, ".pos_ext_vld"}, 32'(pos_ext_vld), 32'(e.pev));
         chk({e.name, ".jump_err"}, 32'(jump_err), 32'(e.je));
         chk({e.name, ".vel_vld"}, 32'(vel_vld), 32'(e.vv));
         chk({e.name, ".vel"}, 32'(vel), 32'(e.vl));
         chk({e.name, ".timeout_err"}, 32'(timeout_err), 32'(e.te));
         chk({e.name, ".fault"}, 32'(fault), 32'(e.f));
      end
   end

   task automatic step();
      @(posedge enc_clk);
      #1;
   endtask

   task automatic exp_now(input string nm, input logic [15:0] pe, input logic pev,
                          input logic je, input logic vv, input logic [10:0] vl,
                          input logic te, input logic f);
      exp_t e;
      e.due = cyc; e.name = nm; e.pe = pe; e.pev = pev; e.je = je;
      e.vv = vv; e.vl = vl; e.te = te; e.f = f;
      sb.push_back(e);
   endtask

   task automatic sample(input logic [39:0] p);
      pos_in  = p;
      pos_vld = 1'b1;
      step();
      pos_vld = 1'b0;
   endtask

   task automatic do_reset(input string nm);
      rst = 1'b1;
      step();
      step();
      exp_now(nm, 16'h0, 0, 0, 0, 11'h0, 0, 0);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; pos_vld = 1'b0; fault_clr = 1'b0; pos_in = '0;

      // rebase
      do_reset("reset");
      sample(40'h10);   exp_now("rebase", 16, 1, 0, 0, 0, 0, 0);
      step();           exp_now("rebase_hold", 16, 1, 0, 0, 0, 0, 0);

      // forward wrap 0xFC -> 0x02 is +6
      do_reset("reset2");
      sample(40'hFC);   exp_now("fwd_first", 252, 1, 0, 0, 0, 0, 0);
      sample(40'h02);   exp_now("fwd_wrap", 258, 1, 0, 0, 0, 0, 0);

      // reverse wrap 0x03 -> 0xFD is -6
      do_reset("reset3");
      sample(40'h03);   exp_now("rev_first", 3, 1, 0, 0, 0, 0, 0);
      sample(40'hFD);   exp_now("rev_wrap", 16'hFFFD, 1, 0, 0, 0, 0, 0);

      // jump reject, three in a row -> FAULT; samples ignored in FAULT
      do_reset("reset4");
      sample(40'h10);   exp_now("jmp_base", 16, 1, 0, 0, 0, 0, 0);
      sample(40'h40);   exp_now("jump1", 16, 1, 1, 0, 0, 0, 0);
      step();           exp_now("jump_pulse_end", 16, 1, 0, 0, 0, 0, 0);
      sample(40'h40);   exp_now("jump2", 16, 1, 1, 0, 0, 0, 0);
      sample(40'h40);   exp_now("jump3_fault", 16, 0, 1, 0, 0, 0, 1);
      sample(40'h10);   exp_now("fault_ignores", 16, 0, 0, 0, 0, 0, 1);

      // velocity window of 4 deltas of +5, then step boundaries
      do_reset("reset5");
      sample(40'd0);    exp_now("vel_base", 0, 1, 0, 0, 0, 0, 0);
      sample(40'd5);    exp_now("vel_s1", 5, 1, 0, 0, 0, 0, 0);
      fault_clr = 1'b1; // no effect outside FAULT
      sample(40'd10);   exp_now("clr_in_run", 10, 1, 0, 0, 0, 0, 0);
      fault_clr = 1'b0;
      sample(40'd15);   exp_now("vel_s3", 15, 1, 0, 0, 0, 0, 0);
      vq.push_back(11'd20);
      sample(40'd20);   exp_now("vel_win", 20, 1, 0, 1, 20, 0, 0);
      step();           exp_now("vel_pulse_end", 20, 1, 0, 0, 20, 0, 0);
      sample(40'd36);   exp_now("max_step_ok", 36, 1, 0, 0, 20, 0, 0);
      sample(40'd53);   exp_now("step17_rej", 36, 1, 1, 0, 20, 0, 0);
      sample(40'hA4);   exp_now("half_range_rej", 36, 1, 1, 0, 20, 0, 0);
      sample(40'd30);   exp_now("accept_after_rej", 30, 1, 0, 0, 20, 0, 0);
      sample(40'd99);   exp_now("rej_cnt_restart", 30, 1, 1, 0, 20, 0, 0);

      // reset mid-operation, then timeout handling
      do_reset("reset_midop");
      sample(40'h10);   exp_now("tmo_base", 16, 1, 0, 0, 0, 0, 0);
      repeat (19) step();
      exp_now("pre_timeout", 16, 1, 0, 0, 0, 0, 0);
      sample(40'h12);   exp_now("vld_beats_timeout", 18, 1, 0, 0, 0, 0, 0);
      repeat (19) step();
      exp_now("no_timeout_yet", 18, 1, 0, 0, 0, 0, 0);
      step();           exp_now("timeout", 18, 0, 0, 0, 0, 1, 1);
      fault_clr = 1'b1; pos_in = 40'h80; pos_vld = 1'b1;
      step();
      fault_clr = 1'b0; pos_vld = 1'b0;
      exp_now("clear_drops", 18, 0, 0, 0, 0, 0, 0);
      sample(40'h30);   exp_now("rebase_after_clr", 48, 1, 0, 0, 0, 0, 0);

      step();
      step();
      chk("sb_drained", 32'(sb.size()), 0);
      chk("vel_q_drained", 32'(vq.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
      $finish;
   end

endmodule
